// File: rtl/lcd_sync_param.sv
// Parametrised LCD timing generator: pixel-clock divider, H/V counters, sync, data enable,
// pixel coordinates, line/frame strobes and frame counter. Define LCD_SYNC_PATTERN_EN to add colour-bar R/G/B.
module lcd_sync_param #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_PW     = 1,
    parameter int H_BP     = 45,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_PW     = 1,
    parameter int V_BP     = 22,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FCNT_W   = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    output logic                        NCLK,
    output logic                        GREST,
    output logic                        HD,
    output logic                        VD,
    output logic                        DEN,
    output logic [$clog2(H_ACTIVE)-1:0] columna,
    output logic [$clog2(V_ACTIVE)-1:0] fila,
    output logic                        LINE_START,
    output logic                        FRAME_START,
    output logic [FCNT_W-1:0]           FRAME_CNT
`ifdef LCD_SYNC_PATTERN_EN
    ,
    output logic [7:0]                  R,
    output logic [7:0]                  G,
    output logic [7:0]                  B
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int COL_W   = $clog2(H_ACTIVE);
    localparam int ROW_W   = $clog2(V_ACTIVE);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_PW);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_PW);

    logic [DW-1:0]    div_cnt;
    logic [DW-1:0]    div_nxt;
    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             line_first;
    logic             frame_first;
    logic             den_d;
    logic             hs_d;
    logic             vs_d;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;

    // Decode of the current position; registered on the tick edge, hence one tick of latency.
    always_comb begin
        // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
        tick        = (div_cnt == DIV_LAST);
        div_nxt     = tick ? '0 : div_cnt + 1'b1;
        h_last      = (hcnt == H_LAST);
        v_last      = (vcnt == V_LAST);
        line_first  = (hcnt == '0);
        frame_first = line_first && (vcnt == '0);
        den_d       = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_d        = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_d        = (vcnt >= VS_BEG) && (vcnt < VS_END);
        col_d       = den_d ? hcnt[COL_W-1:0] : '0;
        row_d       = den_d ? vcnt[ROW_W-1:0] : '0;
    end

`ifdef LCD_SYNC_PATTERN_EN
    localparam int            BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [HW-1:0] BAR_DIV = HW'(BAR_W);
    localparam logic [HW-1:0] BAR_MAX = HW'(7);

    logic [HW-1:0] bar_raw;
    logic [2:0]    bar;

    // Bar index bits map straight to channels: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_raw = hcnt / BAR_DIV;
        bar     = (bar_raw > BAR_MAX) ? 3'd7 : bar_raw[2:0];
    end
`endif

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            div_cnt     <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            FRAME_CNT   <= '0;
            NCLK        <= 1'b0;
            GREST       <= 1'b0;
            DEN         <= 1'b0;
            columna     <= '0;
            fila        <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            HD          <= ~HS_POL;
            VD          <= ~VS_POL;
`ifdef LCD_SYNC_PATTERN_EN
            R           <= 8'h00;
            G           <= 8'h00;
            B           <= 8'h00;
`endif
        end else begin
            div_cnt     <= div_nxt;
            NCLK        <= (div_nxt >= DIV_HALF);
            GREST       <= 1'b1;
            LINE_START  <= tick && line_first;
            FRAME_START <= tick && frame_first;
            if (tick) begin
                DEN     <= den_d;
                columna <= col_d;
                fila    <= row_d;
                HD      <= hs_d ? HS_POL : ~HS_POL;
                VD      <= vs_d ? VS_POL : ~VS_POL;
`ifdef LCD_SYNC_PATTERN_EN
                R       <= (den_d && !bar[1]) ? 8'hFF : 8'h00;
                G       <= (den_d && !bar[2]) ? 8'hFF : 8'h00;
                B       <= (den_d && !bar[0]) ? 8'hFF : 8'h00;
`endif
                if (frame_first) begin
                    FRAME_CNT <= FRAME_CNT + 1'b1;
                end
                if (h_last) begin
                    hcnt <= '0;
                    vcnt <= v_last ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule
